// File: rtl/usb_tx_timer.sv
// -----------------------------------------------------------------------------
// usb_tx_timer
//   Bit-slot timing generator for the USB 1.0 transmit path. Each slot lasts
//   CLKS_PER_BIT clocks. At every slot start one of two strobes fires:
//   bit_strobe (shift the next data bit out) or stuff_strobe (insert a stuff
//   bit). Data bits are counted within a byte, and byte_done flags the end of
//   the 8th data bit so the TX controller can load the next byte.
//
// Ports
//   clk           in   system clock, all state on rising edge
//   n_rst         in   asynchronous active-low reset
//   clear         in   synchronous abort to IDLE, overrides every other input
//   start         in   begin transmission (sampled in IDLE)
//   stop          in   end transmission at the next byte boundary (RUN only)
//   stuff_req     in   next slot is a stuff bit (sampled at slot boundaries)
//   bit_strobe    out  1-cycle pulse: a data bit slot begins
//   stuff_strobe  out  1-cycle pulse: a stuff bit slot begins
//   byte_done     out  1-cycle pulse: 8th data bit of a byte has ended
//   bit_cnt       out  index of current/next data bit, 0..7
//   busy          out  high while in RUN
//
// States
//   IDLE | waiting for start, all outputs low
//   RUN  | timing bit slots, busy high
// -----------------------------------------------------------------------------
module usb_tx_timer #(
  parameter int CLKS_PER_BIT = 8,  // must be >= 2
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       start,
  input  logic       stop,
  input  logic       stuff_req,
  output logic       bit_strobe,
  output logic       stuff_strobe,
  output logic       byte_done,
  output logic [2:0] bit_cnt,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state;
  logic [CNT_W-1:0] clk_cnt;
  logic             stop_pend;
  logic             prev_data;   // last slot carried a data bit (not stuff)

  logic             slot_end;
  logic             wrap;

  assign slot_end = (clk_cnt == '0);
  // bit_cnt only advances after a data slot, so a wrap needs prev_data.
  assign wrap     = slot_end && prev_data && (bit_cnt == 3'd7);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      clk_cnt      <= '0;
      bit_cnt      <= 3'd0;
      stop_pend    <= 1'b0;
      prev_data    <= 1'b0;
      bit_strobe   <= 1'b0;
      stuff_strobe <= 1'b0;
      byte_done    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      bit_strobe   <= 1'b0;
      stuff_strobe <= 1'b0;
      byte_done    <= 1'b0;

      if (clear) begin
        state     <= IDLE;
        clk_cnt   <= '0;
        bit_cnt   <= 3'd0;
        stop_pend <= 1'b0;
        prev_data <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state      <= RUN;
              busy       <= 1'b1;
              bit_strobe <= 1'b1;
              bit_cnt    <= 3'd0;
              clk_cnt    <= RELOAD;
              prev_data  <= 1'b1;
              stop_pend  <= 1'b0;
            end
          end

          RUN: begin
            if (!slot_end) begin
              clk_cnt <= clk_cnt - CNT_W'(1);
              if (stop) stop_pend <= 1'b1;
            end else begin
              clk_cnt <= RELOAD;
              // A stuff slot holds the data bit index.
              if (prev_data) bit_cnt <= bit_cnt + 3'd1;
              if (wrap) byte_done <= 1'b1;

              // A stop seen on this very edge still ends on this wrap.
              if (wrap && (stop_pend || stop)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                clk_cnt   <= '0;
                stop_pend <= 1'b0;
                prev_data <= 1'b0;
              end else begin
                if (stop) stop_pend <= 1'b1;
                if (stuff_req) begin
                  stuff_strobe <= 1'b1;
                  prev_data    <= 1'b0;
                end else begin
                  bit_strobe <= 1'b1;
                  prev_data  <= 1'b1;
                end
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_timer.sv
// -----------------------------------------------------------------------------
// tb_usb_tx_timer
//   Scoreboard bench for usb_tx_timer (CLKS_PER_BIT=8). The stimulus process
//   drives inputs on the falling edge, advances a slot/bit-count reference
//   model for the coming rising edge and queues the expected outputs. The
//   monitor pops one entry per rising edge and compares.
// -----------------------------------------------------------------------------
module tb_usb_tx_timer;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       clear, start, stop, stuff_req;
  logic       bit_strobe, stuff_strobe, byte_done, busy;
  logic [2:0] bit_cnt;

  usb_tx_timer #(.CLKS_PER_BIT(N)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .start        (start),
    .stop         (stop),
    .stuff_req    (stuff_req),
    .bit_strobe   (bit_strobe),
    .stuff_strobe (stuff_strobe),
    .byte_done    (byte_done),
    .bit_cnt      (bit_cnt),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       bs;
    logic       ss;
    logic       bd;
    logic [2:0] cnt;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: age within the current slot, total data bits sent in
  // this transmission, kind of the last slot, and a pending stop request.
  bit m_run;
  int m_age;
  int m_bits;
  bit m_last_data;
  bit m_stop;

  task automatic model_reset();
    m_run = 0; m_age = 0; m_bits = 0; m_last_data = 0; m_stop = 0;
  endtask

  task automatic model_edge(input bit cl, input bit st, input bit sp,
                            input bit sr, output obs_t o);
    o = '0;
    if (cl) begin
      model_reset();
    end else if (!m_run) begin
      if (st) begin
        m_run = 1; m_age = 0; m_bits = 0; m_last_data = 1; m_stop = 0;
        o.bs = 1;
      end
    end else if (m_age < N - 1) begin
      m_age++;
      if (sp) m_stop = 1;
    end else begin
      m_age = 0;
      if (m_last_data) begin
        m_bits++;
        o.bd = (m_bits % 8 == 0);
      end
      if (o.bd && (m_stop || sp)) begin
        m_run = 0; m_stop = 0; m_last_data = 0;
      end else begin
        if (sp) m_stop = 1;
        if (sr) begin o.ss = 1; m_last_data = 0; end
        else    begin o.bs = 1; m_last_data = 1; end
      end
    end
    o.cnt  = 3'(m_bits % 8);
    o.busy = m_run;
  endtask

  task automatic drive(input bit cl, input bit st, input bit sp, input bit sr);
    obs_t o;
    @(negedge clk);
    n_rst = 1; clear = cl; start = st; stop = sp; stuff_req = sr;
    model_edge(cl, st, sp, sr, o);
    exp_q.push_back(o);
  endtask

  // Reset lands mid-cycle, well away from either clock edge.
  task automatic async_reset();
    @(negedge clk);
    clear = 0; start = 1'($urandom); stop = 1'($urandom); stuff_req = 1'($urandom);
    #3 n_rst = 0;
    #1;
    total++;
    if ({bit_strobe, stuff_strobe, byte_done, bit_cnt, busy} !== 7'd0) begin
      bad++;
      $display("FAIL async_reset @%0t: got bs=%b ss=%b bd=%b cnt=%0d busy=%b, expected all 0",
               $time, bit_strobe, stuff_strobe, byte_done, bit_cnt, busy);
    end
    model_reset();
    exp_q.push_back('0);
  endtask

  // Start at E0, optional stuff_req / stop pulse at edge offsets from E0.
  task automatic directed(input int stuff_at, input int stop_at, input int len);
    for (int i = 0; i < len; i++)
      drive(1'b0, i == 0, i == stop_at, i == stuff_at);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(posedge clk);
      #1;
      a = {bit_strobe, stuff_strobe, byte_done, bit_cnt, busy};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard @%0t: got an edge with no queued expectation", $time);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL outputs @%0t: got bs=%b ss=%b bd=%b cnt=%0d busy=%b, expected bs=%b ss=%b bd=%b cnt=%0d busy=%b",
                   $time, a.bs, a.ss, a.bd, a.cnt, a.busy, e.bs, e.ss, e.bd, e.cnt, e.busy);
        end
      end
    end
  end

  initial begin : stimulus
    n_rst = 0; clear = 0; start = 0; stop = 0; stuff_req = 0;
    model_reset();
    exp_q.push_back('0);
    drive(0, 0, 0, 0);

    // Plain byte, then a stuff slot mid-byte, then stop at E10.
    directed(-1, -1, 70);
    drive(1, 0, 0, 0);
    directed(24, -1, 80);
    drive(1, 0, 0, 0);
    directed(-1, 10, 80);
    // Stop pulse on the wrap edge itself.
    directed(-1, 64, 75);
    // Stuff right after bit 7, and back-to-back stuff slots.
    directed(64, -1, 80);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 1; i < 40; i++) drive(0, 0, 0, (i >= 16 && i <= 24));
    // stop and stuff_req while idle must be ignored.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(0, 0, 1, 1);
    // Reset at E20+3 and clear at E30, each followed by a fresh start.
    directed(-1, -1, 20);
    async_reset();
    directed(-1, -1, 30);
    drive(1, 1, 1, 1);
    directed(-1, -1, 20);
    drive(1, 0, 0, 0);

    for (int i = 0; i < 5000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 2) async_reset();
      else drive(r < 5, $urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
